// File: rtl/servo_pkg.sv
// Shared definitions for the servo PWM blocks: decoder FSM states, default
// pulse limits and the clock-to-microsecond divisor helper.
package servo_pkg;

    typedef enum logic [1:0] {
        WAIT_LOW  = 2'd0,
        WAIT_RISE = 2'd1,
        HIGH      = 2'd2
    } servo_state_t;

    localparam int DEF_CLK_HZ       = 50_000_000;
    localparam int DEF_MIN_US       = 500;
    localparam int DEF_MAX_US       = 2500;
    localparam int DEF_POS_LO_US    = 1000;
    localparam int DEF_POS_HI_US    = 2000;
    localparam int DEF_TIMEOUT_US   = 25000;
    localparam int DEF_DEGLITCH_CYC = 8;

    localparam int WIDTH_W   = 12;
    localparam int POS_W     = 10;
    localparam int TIMEOUT_W = 15;

    // Number of clock cycles in one microsecond.
    function automatic int cycles_per_us(input int clk_hz);
        return clk_hz / 1_000_000;
    endfunction

    // Clamp a width into [lo, hi] and express it as an offset from lo.
    function automatic logic [POS_W-1:0] pos_code(input logic [WIDTH_W-1:0] width,
                                                   input logic [WIDTH_W-1:0] lo,
                                                   input logic [WIDTH_W-1:0] hi);
        logic [WIDTH_W-1:0] clamped;
        logic [WIDTH_W-1:0] offset;
        clamped = (width < lo) ? lo : ((width > hi) ? hi : width);
        offset  = clamped - lo;
        return offset[POS_W-1:0];
    endfunction

endpackage

// File: rtl/servo_us_tick.sv
// Microsecond prescaler: counts 0..DIV-1 and pulses tick for one cycle at
// the top of each count. clr restarts the count so the next tick lands
// exactly DIV cycles later.
module servo_us_tick
    import servo_pkg::*;
#(
    parameter int DIV = cycles_per_us(DEF_CLK_HZ)
) (
    input  logic mclk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Prescale counter with synchronous restart.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge mclk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/servo_pulse_decoder.sv
// Servo pulse decoder: measures the high time of pwm_in in microseconds,
// validates it against MIN_US..MAX_US, reports width and clamped position,
// and tracks loss of signal with a rise-to-rise timeout.
// Optional input deglitch filter: define SERVO_PULSE_DEGLITCH_EN.
module servo_pulse_decoder
    import servo_pkg::*;
#(
    parameter int CLK_HZ       = DEF_CLK_HZ,
    parameter int MIN_US       = DEF_MIN_US,
    parameter int MAX_US       = DEF_MAX_US,
    parameter int POS_LO_US    = DEF_POS_LO_US,
    parameter int POS_HI_US    = DEF_POS_HI_US,
    parameter int TIMEOUT_US   = DEF_TIMEOUT_US,
    parameter int DEGLITCH_CYC = DEF_DEGLITCH_CYC
) (
    input  logic                mclk,
    input  logic                rst,
    input  logic                pwm_in,
    output logic [WIDTH_W-1:0]  width_us,
    output logic [POS_W-1:0]    pos,
    output logic                width_valid,
    output logic                err_pulse,
    output logic                link_ok,
    output logic [0:0]          Led
);

    localparam int DIV = cycles_per_us(CLK_HZ);
    localparam logic [WIDTH_W-1:0]   MIN_W  = WIDTH_W'(MIN_US);
    localparam logic [WIDTH_W-1:0]   MAX_W  = WIDTH_W'(MAX_US);
    localparam logic [WIDTH_W-1:0]   LO_W   = WIDTH_W'(POS_LO_US);
    localparam logic [WIDTH_W-1:0]   HI_W   = WIDTH_W'(POS_HI_US);
    localparam logic [TIMEOUT_W-1:0] TO_LIM = TIMEOUT_W'(TIMEOUT_US);

    // After reset the input pipeline (synchronizer, plus the filter when
    // present) still shows the reset level; wait for it to refill so a pin
    // that is already high is not mistaken for a fresh low.
    localparam int SETTLE_CYC = DEGLITCH_CYC + 3;
    localparam int SETTLE_W   = $clog2(SETTLE_CYC + 1);

    logic sync1, sync2, pwm_s, pwm_d;
    logic rise, fall;
    logic [SETTLE_W-1:0] settle_cnt;
    logic settled;

    servo_state_t state, state_nxt;
    logic start, accept, reject;
    logic free_tick, meas_tick;
    logic [WIDTH_W-1:0]   width_cnt, width_next;
    logic [TIMEOUT_W-1:0] to_cnt;
    logic to_hit;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge mclk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
        end
    end

`ifdef SERVO_PULSE_DEGLITCH_EN
    localparam int DG_W = $clog2(DEGLITCH_CYC + 1);
    logic [DG_W-1:0] dg_cnt;

    // Accept a new level only after it has held for DEGLITCH_CYC cycles.
    always_ff @(posedge mclk) begin
        if (rst) begin
            pwm_s  <= 1'b0;
            dg_cnt <= '0;
        end else if (sync2 == pwm_s) begin
            dg_cnt <= '0;
        end else if (dg_cnt == DG_W'(DEGLITCH_CYC - 1)) begin
            pwm_s  <= sync2;
            dg_cnt <= '0;
        end else begin
            dg_cnt <= dg_cnt + 1'b1;
        end
    end
`else
    assign pwm_s = sync2;
`endif

    // Delayed copy of the clean input for edge detection, and post-reset settle count.
    always_ff @(posedge mclk) begin
        if (rst) begin
            pwm_d      <= 1'b0;
            settle_cnt <= '0;
        end else begin
            pwm_d <= pwm_s;
            if (!settled) begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    assign settled = (settle_cnt == SETTLE_W'(SETTLE_CYC));
    assign rise    = pwm_s & ~pwm_d;
    assign fall    = ~pwm_s & pwm_d;

    servo_us_tick #(.DIV(DIV)) u_free_tick (
        .mclk (mclk),
        .rst  (rst),
        .clr  (1'b0),
        .tick (free_tick)
    );

    servo_us_tick #(.DIV(DIV)) u_meas_tick (
        .mclk (mclk),
        .rst  (rst),
        .clr  (start),
        .tick (meas_tick)
    );

    // Width including this cycle's tick, so a fall on a tick boundary counts it.
    assign width_next = width_cnt + {{(WIDTH_W-1){1'b0}}, meas_tick};
    assign to_hit     = (to_cnt == TO_LIM);

    // FSM state register.
    always_ff @(posedge mclk) begin
        if (rst) begin
            state <= WAIT_LOW;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_LOW:  if (settled && !pwm_s) state_nxt = WAIT_RISE;
            WAIT_RISE: if (rise) state_nxt = HIGH;
            HIGH: begin
                if (fall) begin
                    state_nxt = WAIT_RISE;
                end else if (width_next > MAX_W) begin
                    state_nxt = WAIT_LOW;
                end
            end
            default:   state_nxt = WAIT_LOW;
        endcase
    end

    // FSM decisions: start a measurement, accept or reject a pulse.
    always_comb begin
        start  = 1'b0;
        accept = 1'b0;
        reject = 1'b0;
        case (state)
            WAIT_RISE: start = rise;
            HIGH: begin
                if (fall) begin
                    if (width_next >= MIN_W && width_next <= MAX_W) begin
                        accept = 1'b1;
                    end else begin
                        reject = 1'b1;
                    end
                end else if (width_next > MAX_W) begin
                    reject = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Width counter: cleared on the rising edge, advances once per microsecond while high.
    always_ff @(posedge mclk) begin
        if (rst || start) begin
            width_cnt <= '0;
        end else if (state == HIGH) begin
            width_cnt <= width_next;
        end
    end

    // Saturating microseconds-since-last-rise counter.
    always_ff @(posedge mclk) begin
        if (rst || start) begin
            to_cnt <= '0;
        end else if (free_tick && !to_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Registered reports; an accepted pulse outranks a simultaneous timeout.
    always_ff @(posedge mclk) begin
        if (rst) begin
            width_us    <= '0;
            pos         <= '0;
            width_valid <= 1'b0;
            err_pulse   <= 1'b0;
            link_ok     <= 1'b0;
        end else begin
            width_valid <= accept;
            err_pulse   <= reject;
            if (accept) begin
                width_us <= width_next;
                pos      <= pos_code(width_next, LO_W, HI_W);
                link_ok  <= 1'b1;
            end else if (to_hit) begin
                link_ok  <= 1'b0;
            end
        end
    end

    assign Led[0] = link_ok;

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Self-checking bench for servo_pulse_decoder. Runs at a 2 MHz clock
// (2 cycles per us) with a shortened timeout so the run stays short.
module tb_servo_pulse_decoder;

    localparam int CLK_HZ = 2_000_000;
    localparam int DIV    = 2;
    localparam int MIN_US = 500;
    localparam int MAX_US = 2500;
    localparam int LO_US  = 1000;
    localparam int HI_US  = 2000;
    localparam int TO_US  = 4000;
    localparam int DG_CYC = 8;

    logic        mclk = 1'b0;
    logic        rst;
    logic        pwm_in;
    logic [11:0] width_us;
    logic [9:0]  pos;
    logic        width_valid;
    logic        err_pulse;
    logic        link_ok;
    logic [0:0]  Led;

    always #5 mclk = ~mclk;

    servo_pulse_decoder #(
        .CLK_HZ       (CLK_HZ),
        .MIN_US       (MIN_US),
        .MAX_US       (MAX_US),
        .POS_LO_US    (LO_US),
        .POS_HI_US    (HI_US),
        .TIMEOUT_US   (TO_US),
        .DEGLITCH_CYC (DG_CYC)
    ) dut (
        .mclk        (mclk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .width_us    (width_us),
        .pos         (pos),
        .width_valid (width_valid),
        .err_pulse   (err_pulse),
        .link_ok     (link_ok),
        .Led         (Led)
    );

    typedef struct {
        bit is_err;
        int w;
        int p;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  rise_cyc = 0;
    bit  exp_link = 1'b0;
    int  exp_w = 0;
    int  exp_p = 0;

    always @(posedge mclk) cyc <= cyc + 1;

    // Event monitor, sampled mid-cycle.
    always @(negedge mclk) begin
        ev_t e;
        if (width_valid === 1'b1) begin
            e.is_err = 1'b0; e.w = int'(width_us); e.p = int'(pos);
            obs_q.push_back(e);
        end
        if (err_pulse === 1'b1) begin
            e.is_err = 1'b1; e.w = 0; e.p = 0;
            obs_q.push_back(e);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, observed cyc=%0d required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pos_of(input int w);
        if (w < LO_US) return 0;
        if (w > HI_US) return HI_US - LO_US;
        return w - LO_US;
    endfunction

    // Reference: one clean high segment of hi_cyc clock cycles.
    task automatic expect_segment(input int hi_cyc);
        ev_t e;
        int  w;
        w = hi_cyc / DIV;
        if (w >= MIN_US && w <= MAX_US) begin
            e.is_err = 1'b0; e.w = w; e.p = pos_of(w);
            exp_link = 1'b1; exp_w = w; exp_p = pos_of(w);
        end else begin
            e.is_err = 1'b1; e.w = 0; e.p = 0;
        end
        exp_q.push_back(e);
    endtask

    task automatic drive(input int hi1, input int glitch, input int hi2, input int gap);
        @(posedge mclk); #1;
        pwm_in = 1'b1;
        rise_cyc = cyc;
        repeat (hi1) @(posedge mclk);
        #1;
        if (glitch > 0) begin
            pwm_in = 1'b0;
            repeat (glitch) @(posedge mclk);
            #1;
            pwm_in = 1'b1;
            repeat (hi2) @(posedge mclk);
            #1;
        end
        pwm_in = 1'b0;
        repeat (gap) @(posedge mclk);
        #1;
    endtask

    task automatic compare_events(input string tag);
        check({tag, ".count"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            check({tag, ".kind"}, int'(obs_q[i].is_err), int'(exp_q[i].is_err));
            check({tag, ".width"}, obs_q[i].w, exp_q[i].w);
            check({tag, ".pos"}, obs_q[i].p, exp_q[i].p);
        end
        check({tag, ".width_us"}, int'(width_us), exp_w);
        check({tag, ".pos_hold"}, int'(pos), exp_p);
        check({tag, ".link_ok"}, int'(link_ok), int'(exp_link));
        check({tag, ".led"}, int'(Led[0]), int'(exp_link));
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        pwm_in = 1'b0;
        repeat (5) @(posedge mclk);
        #1;
        check("reset.width_us", int'(width_us), 0);
        check("reset.pos", int'(pos), 0);
        check("reset.valid", int'(width_valid), 0);
        check("reset.err", int'(err_pulse), 0);
        check("reset.link", int'(link_ok), 0);

        // Pin already high when reset releases: partial pulse must be ignored.
        pwm_in = 1'b1;
        repeat (3) @(posedge mclk);
        #1 rst = 1'b0;
        repeat (2400) @(posedge mclk);
        #1 pwm_in = 1'b0;
        repeat (400) @(posedge mclk);
        #1;
        compare_events("partial");

        drive(3000, 0, 0, 400); expect_segment(3000); compare_events("p1500");
        drive(1600, 0, 0, 400); expect_segment(1600); compare_events("p800");
        drive(4400, 0, 0, 400); expect_segment(4400); compare_events("p2200");
        drive(800, 0, 0, 400);  expect_segment(800);  compare_events("p400");
        drive(6000, 0, 0, 400); expect_segment(6000); compare_events("hold3000");

        // Loss of signal: valid pulse, then input stays low past the timeout.
        drive(3000, 0, 0, 400); expect_segment(3000); compare_events("pre_timeout");
        while (cyc < rise_cyc + TO_US * DIV - 10) @(posedge mclk);
        #1;
        check("timeout.before", int'(link_ok), 1);
        while (cyc < rise_cyc + TO_US * DIV + 10) @(posedge mclk);
        #1;
        check("timeout.after", int'(link_ok), 0);
        check("timeout.led", int'(Led[0]), 0);
        check("timeout.width_hold", int'(width_us), 1500);
        exp_link = 1'b0;
        drive(3000, 0, 0, 400); expect_segment(3000); compare_events("relink");

        // Reset in the middle of a pulse.
        @(posedge mclk); #1 pwm_in = 1'b1;
        repeat (1000) @(posedge mclk);
        #1 rst = 1'b1;
        @(posedge mclk);
        #1;
        check("rst_mid.width_us", int'(width_us), 0);
        check("rst_mid.pos", int'(pos), 0);
        check("rst_mid.valid", int'(width_valid), 0);
        check("rst_mid.err", int'(err_pulse), 0);
        check("rst_mid.link", int'(link_ok), 0);
        rst = 1'b0;
        exp_link = 1'b0; exp_w = 0; exp_p = 0;
        repeat (2000) @(posedge mclk);
        #1 pwm_in = 1'b0;
        repeat (400) @(posedge mclk);
        #1;
        obs_q.delete();
        compare_events("rst_mid");
        drive(3000, 0, 0, 400); expect_segment(3000); compare_events("after_rst");

        // 5-cycle low glitch inside a 1500 us pulse.
        drive(400, 5, 2595, 400);
`ifdef SERVO_PULSE_DEGLITCH_EN
        expect_segment(400 + 5 + 2595);
`else
        expect_segment(400);
        expect_segment(2595);
`endif
        compare_events("glitch");

        // Random widths across reject-low, valid and abort regions.
        for (int i = 0; i < 6; i++) begin
            int hi;
            int gap;
            hi  = int'($urandom_range(5300, 800));
            gap = int'($urandom_range(500, 150));
            drive(hi, 0, 0, gap);
            expect_segment(hi);
            compare_events("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
